// File: rtl/nibble_pkg.sv
// Shared types and constants for the nibble selector / packer datapath.
package nibble_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned BEAT_W = 16;

  typedef logic [3:0] nibble_t;
  typedef nibble_t [LANES-1:0] nibble_grp_t;

  typedef enum logic {
    StEmpty,
    StHold
  } pack_state_e;

  // Even parity per byte of a 32-bit word; bit k covers byte k.
  function automatic logic [3:0] byte_parity(input logic [31:0] word);
    logic [3:0] par;
    for (int k = 0; k < 4; k++) begin
      par[k] = ^word[8*k +: 8];
    end
    return par;
  endfunction

endpackage

// File: rtl/nibble_fifo.sv
// Synchronous FIFO with occupancy count; full/empty is decided by the count.
module nibble_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  // Storage is cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mem   <= '{default: '0};
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (i_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (i_push && !i_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!i_push && i_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/nibble_packer.sv
// Packs pairs of 16-bit nibble beats into 32-bit words behind a FIFO.
// Define NIBBLE_PACKER_PARITY_EN to add per-byte parity stored with each word.
module nibble_packer
  import nibble_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  nibble_grp_t i_nibble_in,
  input  logic        i_nibble_valid,
  output logic        o_nibble_ready,
  input  logic        i_flush,
  output logic [31:0] o_data_out,
  output logic        o_valid_out,
  input  logic        i_ready_in,
  output logic [CW-1:0] o_words,
`ifdef NIBBLE_PACKER_PARITY_EN
  output logic [3:0]  o_parity_out,
`endif
  output logic        o_half
);

`ifdef NIBBLE_PACKER_PARITY_EN
  localparam int unsigned FW = 36;
`else
  localparam int unsigned FW = 32;
`endif
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  pack_state_e       r_state;
  pack_state_e       w_state_d;
  logic [BEAT_W-1:0] r_hold;
  logic [BEAT_W-1:0] w_hold_d;
  logic              r_flush_pend;
  logic              w_pend_d;

  logic [BEAT_W-1:0] w_beat;
  logic              w_full;
  logic              w_xfer;
  logic              w_pop;
  logic              w_push;
  logic [31:0]       w_push_word;
  logic [FW-1:0]     w_fifo_wdata;
  logic [FW-1:0]     w_fifo_rdata;
  logic [CW-1:0]     w_count;

  assign w_beat         = i_nibble_in;
  assign w_full         = (w_count == FullCnt);
  assign o_nibble_ready = !r_flush_pend && ((r_state == StEmpty) || !w_full);
  assign w_xfer         = i_nibble_valid && o_nibble_ready;
  assign o_valid_out    = (w_count != '0);
  assign w_pop          = o_valid_out && i_ready_in;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StEmpty;
      r_hold       <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_hold       <= w_hold_d;
      r_flush_pend <= w_pend_d;
    end
  end

  // A transfer always beats a flush; a flush against a full FIFO waits for space.
  always_comb begin
    w_state_d   = r_state;
    w_hold_d    = r_hold;
    w_pend_d    = r_flush_pend;
    w_push      = 1'b0;
    w_push_word = '0;
    case (r_state)
      StEmpty: begin
        if (w_xfer) begin
          w_hold_d  = w_beat;
          w_state_d = StHold;
        end
      end
      StHold: begin
        if (w_xfer) begin
          w_push      = 1'b1;
          w_push_word = {w_beat, r_hold};
          w_state_d   = StEmpty;
        end else if (i_flush || r_flush_pend) begin
          if (!w_full) begin
            w_push      = 1'b1;
            w_push_word = {16'h0, r_hold};
            w_state_d   = StEmpty;
            w_pend_d    = 1'b0;
          end else begin
            w_pend_d = 1'b1;
          end
        end
      end
      default: w_state_d = StEmpty;
    endcase
  end

`ifdef NIBBLE_PACKER_PARITY_EN
  assign w_fifo_wdata = {byte_parity(w_push_word), w_push_word};
  assign o_parity_out = w_fifo_rdata[35:32];
`else
  assign w_fifo_wdata = w_push_word;
`endif

  nibble_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW),
    .CW    (CW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_fifo_wdata),
    .o_rdata (w_fifo_rdata),
    .o_count (w_count)
  );

  assign o_data_out = w_fifo_rdata[31:0];
  assign o_words    = w_count;
  assign o_half     = (r_state == StHold);

endmodule
